// File: rtl/s15611_pkg.sv
// Shared definitions for the S15611 capture sequencer: FSM state encoding,
// SPI word width and the default timing constants.
package s15611_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SPI,
        S_ST_HIGH,
        S_WAIT_FRAME,
        S_WAIT_PERIOD,
        S_FINISH
    } state_t;

    localparam int SPI_WIDTH        = 16;

    localparam int DEF_RSTB_NCLK    = 200;
    localparam int DEF_SPI_CLK_DIV  = 8;
    localparam int DEF_MIN_INT_NCLK = 64;
    localparam int DEF_TIMEOUT_NCLK = 1 << 20;

    // Effective ST high time: short requests are raised to the minimum.
    function automatic logic [31:0] clamp_int(input logic [31:0] req,
                                              input logic [31:0] min_val);
        return (req < min_val) ? min_val : req;
    endfunction

endpackage

// File: rtl/s15611_spi_tx.sv
// 16-bit mode-0 SPI transmitter for the S15611 configuration word.
// cs low for (2*SPI_WIDTH+1) half-periods; mosi changes on sclk falling edges.
module s15611_spi_tx
    import s15611_pkg::*;
#(
    parameter int CLK_DIV = DEF_SPI_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [SPI_WIDTH-1:0] word,
    output logic                 cs,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 done,
    output logic                 active
);

    localparam logic [15:0] DIV_M1   = 16'(CLK_DIV - 1);
    localparam logic [5:0]  LAST_HALF = 6'(2 * SPI_WIDTH);

    logic [SPI_WIDTH-1:0] shift_reg;
    logic [15:0]          div_cnt_reg;
    logic [5:0]           half_cnt_reg;

    // Half-period ticker: odd ticks raise sclk, even ticks lower it and shift,
    // the tick after the last falling edge releases cs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs           <= 1'b1;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            done         <= 1'b0;
            active       <= 1'b0;
            shift_reg    <= '0;
            div_cnt_reg  <= '0;
            half_cnt_reg <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                cs     <= 1'b1;
                sclk   <= 1'b0;
                mosi   <= 1'b0;
                active <= 1'b0;
            end else if (!active) begin
                if (start) begin
                    active       <= 1'b1;
                    cs           <= 1'b0;
                    sclk         <= 1'b0;
                    shift_reg    <= word;
                    mosi         <= word[SPI_WIDTH-1];
                    div_cnt_reg  <= '0;
                    half_cnt_reg <= '0;
                end
            end else if (div_cnt_reg == DIV_M1) begin
                div_cnt_reg  <= '0;
                half_cnt_reg <= half_cnt_reg + 6'd1;
                if (half_cnt_reg == LAST_HALF) begin
                    cs     <= 1'b1;
                    sclk   <= 1'b0;
                    mosi   <= 1'b0;
                    active <= 1'b0;
                    done   <= 1'b1;
                end else if (!half_cnt_reg[0]) begin
                    sclk <= 1'b1;
                end else begin
                    sclk      <= 1'b0;
                    shift_reg <= {shift_reg[SPI_WIDTH-2:0], 1'b0};
                    mosi      <= shift_reg[SPI_WIDTH-2];
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: rtl/s15611_frame_scheduler.sv
// S15611 capture-run sequencer: sensor reset, SPI configuration, then a
// programmed number of ST pulses paced by a period counter, waiting for the
// acquisition block to report each line.
// Optional WAIT_FRAME watchdog: define S15611_FRAME_TIMEOUT_EN.
module s15611_frame_scheduler
    import s15611_pkg::*;
#(
    parameter int RSTB_NCLK    = DEF_RSTB_NCLK,
    parameter int SPI_CLK_DIV  = DEF_SPI_CLK_DIV,
    parameter int MIN_INT_NCLK = DEF_MIN_INT_NCLK
`ifdef S15611_FRAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT_NCLK = DEF_TIMEOUT_NCLK
`endif
) (
    input  logic        master_clock,
    input  logic        resetn,
    input  logic        cfg_start,
    input  logic        cfg_abort,
    input  logic [15:0] cfg_frames,
    input  logic [31:0] cfg_int_time,
    input  logic [31:0] cfg_period,
    input  logic [15:0] cfg_reg_word,
    input  logic        acq_frame_done,
    output logic        s15611_rstb,
    output logic        s15611_mst,
    output logic        s15611_cs,
    output logic        s15611_sclk,
    output logic        s15611_mosi,
    output logic        acq_enable,
    output logic        busy,
    output logic        run_done,
    output logic [15:0] frame_count,
    output logic        overrun,
    output logic        timeout
);

    localparam logic [31:0] RSTB_M1 = 32'(RSTB_NCLK - 1);
    localparam logic [31:0] MIN_INT = 32'(MIN_INT_NCLK);

    state_t      state;
    logic [15:0] frames_reg;
    logic [31:0] int_eff_reg;
    logic [31:0] period_m1_reg;
    logic [15:0] word_reg;
    logic [31:0] rst_cnt_reg;
    logic [31:0] per_cnt_reg;
    logic        spi_start_reg;
    logic        spi_done;
    logic        spi_active;
    logic        wd_fire;
    logic        start_ok;
    logic        abort_cond;
    logic [15:0] fc_inc;

    assign start_ok   = (state == S_IDLE) && cfg_start && !cfg_abort;
    assign abort_cond = (cfg_abort || wd_fire) && (state != S_IDLE) && (state != S_FINISH);
    assign fc_inc     = (frame_count == 16'hFFFF) ? frame_count : frame_count + 16'd1;

`ifdef S15611_FRAME_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_NCLK - 1);
    logic [31:0] wd_cnt_reg;

    assign wd_fire = (state == S_WAIT_FRAME) && (wd_cnt_reg == TIMEOUT_M1);

    // Watchdog restarts while ST is high, so it counts from the ST fall.
    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            wd_cnt_reg <= '0;
        end else if (state == S_ST_HIGH) begin
            wd_cnt_reg <= '0;
        end else if (state == S_WAIT_FRAME && wd_cnt_reg != '1) begin
            wd_cnt_reg <= wd_cnt_reg + 32'd1;
        end
    end

    // Sticky timeout flag, cleared by an accepted start.
    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            timeout <= 1'b0;
        end else if (start_ok) begin
            timeout <= 1'b0;
        end else if (wd_fire) begin
            timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    s15611_spi_tx #(
        .CLK_DIV (SPI_CLK_DIV)
    ) u_spi (
        .clk    (master_clock),
        .rst_n  (resetn),
        .start  (spi_start_reg),
        .abort  (abort_cond),
        .word   (word_reg),
        .cs     (s15611_cs),
        .sclk   (s15611_sclk),
        .mosi   (s15611_mosi),
        .done   (spi_done),
        .active (spi_active)
    );

    // Run sequencer; abort (or watchdog) overrides every state except IDLE/FINISH.
    always_ff @(posedge master_clock or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            frames_reg    <= '0;
            int_eff_reg   <= '0;
            period_m1_reg <= '0;
            word_reg      <= '0;
            rst_cnt_reg   <= '0;
            per_cnt_reg   <= '0;
            spi_start_reg <= 1'b0;
            s15611_rstb   <= 1'b0;
            s15611_mst    <= 1'b0;
            acq_enable    <= 1'b0;
            busy          <= 1'b0;
            run_done      <= 1'b0;
            frame_count   <= '0;
            overrun       <= 1'b0;
        end else begin
            spi_start_reg <= 1'b0;
            run_done      <= 1'b0;
            if (per_cnt_reg != '1) begin
                per_cnt_reg <= per_cnt_reg + 32'd1;
            end
            if (abort_cond) begin
                state      <= S_FINISH;
                s15611_mst <= 1'b0;
                acq_enable <= 1'b0;
                run_done   <= 1'b1;
                busy       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            frames_reg    <= cfg_frames;
                            int_eff_reg   <= clamp_int(cfg_int_time, MIN_INT);
                            period_m1_reg <= (cfg_period == 32'd0) ? 32'd0 : cfg_period - 32'd1;
                            word_reg      <= cfg_reg_word;
                            rst_cnt_reg   <= '0;
                            s15611_rstb   <= 1'b0;
                            busy          <= 1'b1;
                            frame_count   <= '0;
                            overrun       <= 1'b0;
                            state         <= S_RST;
                        end
                    end
                    S_RST: begin
                        if (rst_cnt_reg == RSTB_M1) begin
                            s15611_rstb   <= 1'b1;
                            spi_start_reg <= 1'b1;
                            state         <= S_SPI;
                        end else begin
                            rst_cnt_reg <= rst_cnt_reg + 32'd1;
                        end
                    end
                    S_SPI: begin
                        if (spi_done) begin
                            s15611_mst  <= 1'b1;
                            acq_enable  <= 1'b1;
                            per_cnt_reg <= '0;
                            state       <= S_ST_HIGH;
                        end
                    end
                    S_ST_HIGH: begin
                        if (per_cnt_reg == int_eff_reg - 32'd1) begin
                            s15611_mst <= 1'b0;
                            state      <= S_WAIT_FRAME;
                        end
                    end
                    S_WAIT_FRAME: begin
                        // The next ST rise point passing while still waiting is an overrun.
                        if (per_cnt_reg >= period_m1_reg) begin
                            overrun <= 1'b1;
                        end
                        if (acq_frame_done) begin
                            frame_count <= fc_inc;
                            if (frames_reg != 16'd0 && fc_inc == frames_reg) begin
                                acq_enable <= 1'b0;
                                run_done   <= 1'b1;
                                busy       <= 1'b0;
                                state      <= S_FINISH;
                            end else begin
                                state <= S_WAIT_PERIOD;
                            end
                        end
                    end
                    S_WAIT_PERIOD: begin
                        if (per_cnt_reg >= period_m1_reg) begin
                            s15611_mst  <= 1'b1;
                            per_cnt_reg <= '0;
                            state       <= S_ST_HIGH;
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_s15611_frame_scheduler.sv
// Directed bench for s15611_frame_scheduler with an expectation queue.
module tb_s15611_frame_scheduler;

    logic        master_clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [15:0] cfg_frames = '0;
    logic [31:0] cfg_int_time = '0;
    logic [31:0] cfg_period = '0;
    logic [15:0] cfg_reg_word = '0;
    logic        acq_frame_done = 1'b0;
    logic        s15611_rstb, s15611_mst, s15611_cs, s15611_sclk, s15611_mosi;
    logic        acq_enable, busy, run_done, overrun, timeout;
    logic [15:0] frame_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    longint exp_q[$];

    s15611_frame_scheduler #(
        .RSTB_NCLK    (200),
        .SPI_CLK_DIV  (8),
        .MIN_INT_NCLK (64)
`ifdef S15611_FRAME_TIMEOUT_EN
        ,
        .TIMEOUT_NCLK (4096)
`endif
    ) dut (
        .master_clock   (master_clock),
        .resetn         (resetn),
        .cfg_start      (cfg_start),
        .cfg_abort      (cfg_abort),
        .cfg_frames     (cfg_frames),
        .cfg_int_time   (cfg_int_time),
        .cfg_period     (cfg_period),
        .cfg_reg_word   (cfg_reg_word),
        .acq_frame_done (acq_frame_done),
        .s15611_rstb    (s15611_rstb),
        .s15611_mst     (s15611_mst),
        .s15611_cs      (s15611_cs),
        .s15611_sclk    (s15611_sclk),
        .s15611_mosi    (s15611_mosi),
        .acq_enable     (acq_enable),
        .busy           (busy),
        .run_done       (run_done),
        .frame_count    (frame_count),
        .overrun        (overrun),
        .timeout        (timeout)
    );

    always #5 master_clock = ~master_clock;
    always @(posedge master_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
        $display("check %-14s got=%0d expected=%0d", tag, obs, expv);
    endtask

    function automatic longint out_vec();
        return longint'({s15611_rstb, s15611_mst, s15611_cs, s15611_sclk, s15611_mosi,
                         acq_enable, busy, run_done, overrun, timeout, frame_count});
    endfunction

    task automatic start_run(input logic [15:0] fr, input logic [31:0] it,
                             input logic [31:0] per, input logic [15:0] word,
                             output int s_edge);
        @(negedge master_clock);
        cfg_frames = fr; cfg_int_time = it; cfg_period = per; cfg_reg_word = word;
        cfg_start = 1'b1;
        @(negedge master_clock);
        cfg_start = 1'b0;
        // Mid-run changes must not matter.
        cfg_frames = 16'd7; cfg_int_time = 32'd5; cfg_period = 32'd3; cfg_reg_word = 16'h0000;
        s_edge = cyc;
    endtask

    task automatic wait_rise(output int at);
        int n = 0;
        while (s15611_mst !== 1'b1 && n <= 20000) begin
            @(negedge master_clock);
            n++;
        end
        if (n > 20000) check("rise_wait", 0, 1);
        at = cyc;
    endtask

    task automatic measure_high(output int w);
        w = 0;
        while (s15611_mst === 1'b1 && w < 20000) begin
            w++;
            @(negedge master_clock);
        end
    endtask

    task automatic pulse_done_at(input int target);
        int n = 0;
        while (cyc < target - 1 && n < 20000) begin
            @(negedge master_clock);
            n++;
        end
        acq_frame_done = 1'b1;
        @(negedge master_clock);
        acq_frame_done = 1'b0;
    endtask

    initial begin
        int s, r0, r1, r2, w, n, low;
        logic [15:0] word;
        logic prev_sclk;
        longint obs_bits[$];

        // Reset state
        repeat (3) @(negedge master_clock);
        check("reset_outs", out_vec(), longint'(26'b0010000000 << 16));
        resetn = 1'b1;

        // Single line: SPI word, latency, ST width, run_done
        word = 16'hA5C3;
        for (int i = 15; i >= 0; i--) exp_q.push_back(longint'(word[i]));
        exp_q.push_back(466);
        exp_q.push_back(1000);
        start_run(16'd1, 32'd1000, 32'd5000, word, s);
        check("busy_rise", busy, 1);
        n = 0;
        while (s15611_cs !== 1'b0 && n < 1000) begin @(negedge master_clock); n++; end
        low = 0; prev_sclk = 1'b0;
        while (s15611_cs === 1'b0 && low < 1000) begin
            if (s15611_sclk === 1'b1 && prev_sclk === 1'b0) obs_bits.push_back(longint'(s15611_mosi));
            prev_sclk = s15611_sclk;
            low++;
            @(negedge master_clock);
        end
        check("cs_low_len", low, 264);
        check("bit_count", obs_bits.size(), 16);
        for (int i = 0; i < 16; i++) check("mosi_bit", (obs_bits.size() > 0) ? obs_bits.pop_front() : -1, exp_q.pop_front());
        wait_rise(r0);
        check("st_latency", r0 - s, exp_q.pop_front());
        check("acq_en_on", acq_enable, 1);
        measure_high(w);
        check("st_width", w, exp_q.pop_front());
        pulse_done_at(r0 + 3000);
        check("run_done", run_done, 1);
        check("frame_cnt1", frame_count, 1);
        check("busy_fall", busy, 0);
        check("acq_en_off", acq_enable, 0);
        @(negedge master_clock);
        check("run_done_1cyc", run_done, 0);
        check("rstb_high", s15611_rstb, 1);

        // Period timing, three lines
        start_run(16'd3, 32'd1000, 32'd5000, 16'h1234, s);
        wait_rise(r0);
        pulse_done_at(r0 + 2000);
        wait_rise(r1);
        check("period_1", r1 - r0, 5000);
        pulse_done_at(r1 + 2000);
        wait_rise(r2);
        check("period_2", r2 - r1, 5000);
        pulse_done_at(r2 + 2000);
        check("run_done_p", run_done, 1);
        check("frame_cnt3", frame_count, 3);
        check("no_overrun", overrun, 0);

        // Overrun
        start_run(16'd2, 32'd100, 32'd2000, 16'h00FF, s);
        wait_rise(r0);
        pulse_done_at(r0 + 3000);
        wait_rise(r1);
        check("overrun_gap", r1 - r0, 3001);
        check("overrun_flag", overrun, 1);
        pulse_done_at(r1 + 3000);
        check("run_done_o", run_done, 1);
        check("frame_cnt2", frame_count, 2);

        // Integration clamp, overrun cleared by start
        start_run(16'd1, 32'd10, 32'd5000, 16'hFFFF, s);
        check("overrun_clr", overrun, 0);
        wait_rise(r0);
        measure_high(w);
        check("clamp_width", w, 64);
        pulse_done_at(r0 + 200);
        check("run_done_c", run_done, 1);

        // Continuous mode, then abort with frame_count held
        start_run(16'd0, 32'd100, 32'd3000, 16'h8001, s);
        wait_rise(r0);
        pulse_done_at(r0 + 500);
        wait_rise(r1);
        check("cont_period", r1 - r0, 3000);
        pulse_done_at(r1 + 500);
        check("cont_busy", busy, 1);
        wait_rise(r2);
        repeat (20) @(negedge master_clock);
        cfg_abort = 1'b1;
        @(negedge master_clock);
        cfg_abort = 1'b0;
        check("abort_mst", s15611_mst, 0);
        check("abort_fcnt", frame_count, 2);
        check("abort_done", run_done, 1);
        check("abort_acq", acq_enable, 0);

        // Abort mid-SPI
        start_run(16'd1, 32'd1000, 32'd5000, 16'hA5C3, s);
        n = 0;
        while (s15611_cs !== 1'b0 && n < 1000) begin @(negedge master_clock); n++; end
        repeat (44) @(negedge master_clock);
        cfg_abort = 1'b1;
        @(negedge master_clock);
        cfg_abort = 1'b0;
        check("spi_ab_cs", s15611_cs, 1);
        check("spi_ab_sclk", s15611_sclk, 0);
        check("spi_ab_done", run_done, 1);
        check("spi_ab_busy", busy, 0);

        // start together with abort in IDLE is ignored
        repeat (3) @(negedge master_clock);
        cfg_start = 1'b1; cfg_abort = 1'b1;
        @(negedge master_clock);
        cfg_start = 1'b0; cfg_abort = 1'b0;
        check("start_abort", busy, 0);

        // Asynchronous reset mid-ST
        start_run(16'd1, 32'd1000, 32'd5000, 16'h5555, s);
        wait_rise(r0);
        repeat (10) @(negedge master_clock);
        #2 resetn = 1'b0;
        #1 check("async_reset", out_vec(), longint'(26'b0010000000 << 16));
        @(negedge master_clock);
        resetn = 1'b1;

`ifdef S15611_FRAME_TIMEOUT_EN
        // Watchdog: no acq_frame_done
        start_run(16'd1, 32'd100, 32'd5000, 16'h0F0F, s);
        wait_rise(r0);
        measure_high(w);
        r1 = cyc;
        while (cyc < r1 + 4095) @(negedge master_clock);
        check("wd_before", timeout, 0);
        @(negedge master_clock);
        check("wd_timeout", timeout, 1);
        check("wd_run_done", run_done, 1);
`else
        // No watchdog: WAIT_FRAME holds indefinitely
        start_run(16'd1, 32'd100, 32'd5000, 16'h0F0F, s);
        wait_rise(r0);
        repeat (6000) @(negedge master_clock);
        check("no_timeout", timeout, 0);
        check("still_busy", busy, 1);
        cfg_abort = 1'b1;
        @(negedge master_clock);
        cfg_abort = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
